// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and limits for the programmable serial pattern detector.
//   t_state      : detector FSM state (search for a match / hold the y window)
//   PAT_W_MAX    : largest supported pattern length
//   HOLD_CYC_MAX : longest supported y window (fits the 4-bit hold counter)
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int PAT_W_MAX    = 16;
  localparam int HOLD_CYC_MAX = 15;

  typedef enum logic [0:0] {
    S_SEARCH = 1'b0,
    S_HOLD   = 1'b1
  } t_state;

endpackage

// File: rtl/seq_detector_n_if.sv
// ---------------------------------------------------------------------------
// seq_detector_n_if
// Bundles the serial stream, configuration and match outputs of
// seq_detector_n.
//   x, x_valid       : qualified serial bit
//   pattern, overlap : configuration, latched by load
//   load             : latch configuration and restart the search
//   y, match_pulse   : registered match window and one-cycle match strobe
// modport master = stream/config source, modport slave = the detector.
// ---------------------------------------------------------------------------
interface seq_detector_n_if #(
  parameter int PAT_W = 4
);

  logic             x;
  logic             x_valid;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             load;
  logic             y;
  logic             match_pulse;

  modport master (
    output x, x_valid, pattern, overlap, load,
    input  y, match_pulse
  );

  modport slave (
    input  x, x_valid, pattern, overlap, load,
    output y, match_pulse
  );

endinterface

// File: rtl/seq_det_window.sv
// ---------------------------------------------------------------------------
// seq_det_window
// Serial window shift register, fill counter and pattern comparator.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the window (load)
//   accept    : shift x into the window this cycle
//   x         : serial bit
//   keep_fill : 1 = overlapping mode, window stays full after a hit
//   pat       : latched target pattern, MSB received first
//   hit       : combinational; the bit being accepted completes a match
// ---------------------------------------------------------------------------
module seq_det_window #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic             x,
  input  logic             keep_fill,
  input  logic [PAT_W-1:0] pat,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  sh_q, sh_d, sh_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sh_shift = {sh_q[PAT_W-2:0], x};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // Match is judged on the post-shift window so the hit lines up with the
    // edge that accepts the final bit.
    hit      = accept && (fill_inc == FILL_FULL) && (sh_shift == pat);
    sh_d     = sh_q;
    fill_d   = fill_q;
    if (clear) begin
      sh_d   = '0;
      fill_d = '0;
    end else if (accept) begin
      sh_d   = sh_shift;
      // Non-overlapping mode demands PAT_W fresh bits after every match.
      fill_d = (hit && !keep_fill) ? '0 : fill_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      fill_q <= '0;
    end else begin
      sh_q   <= sh_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_n.sv
// ---------------------------------------------------------------------------
// seq_detector_n
// Programmable serial pattern detector with overlapping / non-overlapping
// match modes and a retriggerable HOLD_CYC-cycle match window.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (clears configuration too)
//   bus         : seq_detector_n_if.slave (x, x_valid, pattern, overlap,
//                 load in; y, match_pulse out; all outputs registered)
//   match_count : saturating match counter, present only when
//                 SEQDET_MATCH_CNT_EN is defined
// Optional feature macro: SEQDET_MATCH_CNT_EN
// ---------------------------------------------------------------------------
module seq_detector_n
  import seq_det_pkg::*;
#(
  parameter int PAT_W    = 4,
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_detector_n_if.slave  bus
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_n: PAT_W out of range");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > HOLD_CYC_MAX) begin : g_bad_hold_cyc
    $error("seq_detector_n: HOLD_CYC out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_n: CNT_W must be at least 1");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

  t_state           state_q, state_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic             pulse_q, pulse_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic             accept;
  logic             hit;

  // The bit presented alongside load is discarded.
  assign accept = bus.x_valid && !bus.load;

  seq_det_window #(.PAT_W(PAT_W)) u_window (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.load),
    .accept    (accept),
    .x         (bus.x),
    .keep_fill (ovl_q),
    .pat       (pat_q),
    .hit       (hit)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pulse_d    = 1'b0;
    pat_d      = pat_q;
    ovl_d      = ovl_q;
    if (bus.load) begin
      pat_d      = bus.pattern;
      ovl_d      = bus.overlap;
      state_d    = S_SEARCH;
      hold_cnt_d = '0;
    end else if (hit) begin
      // A hit in either state (re)starts a full window.
      state_d    = S_HOLD;
      hold_cnt_d = HOLD_LOAD;
      pulse_d    = 1'b1;
    end else if (state_q == S_HOLD) begin
      if (hold_cnt_q == '0) begin
        state_d = S_SEARCH;
      end else begin
        hold_cnt_d = hold_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SEARCH;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
      pat_q      <= '0;
      ovl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
      pat_q      <= pat_d;
      ovl_q      <= ovl_d;
    end
  end

  // y is a pure decode of the state flop, so it stays registered.
  assign bus.y           = (state_q == S_HOLD);
  assign bus.match_pulse = pulse_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_n.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_n
// Two detectors (HOLD_CYC = 2 and 4, PAT_W = 4, CNT_W = 2) share one
// directed stimulus stream. A reference model, expressed in terms of
// "bits seen since restart" and "window cycles remaining", predicts the
// outputs of both; a negedge process compares every cycle, and literal
// expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_seq_detector_n;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int HOLD_A = 2;
  localparam int HOLD_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_n_if #(.PAT_W(PAT_W)) if_a ();
  seq_detector_n_if #(.PAT_W(PAT_W)) if_b ();

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_a, cnt_b;
`endif

  seq_detector_n #(.PAT_W(PAT_W), .HOLD_CYC(HOLD_A), .CNT_W(CNT_W)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (if_a)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_count (cnt_a)
`endif
  );

  seq_detector_n #(.PAT_W(PAT_W), .HOLD_CYC(HOLD_B), .CNT_W(CNT_W)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (if_b)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_count (cnt_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, bits accepted since the last restart,
  // the last PAT_W of them, and how many y cycles remain.
  int   m_hold [2] = '{HOLD_A, HOLD_B};
  int   m_nbits[2];
  int   m_win  [2];
  int   m_rem  [2];
  int   m_cnt  [2];
  bit   m_pulse[2];
  int   m_pat;
  bit   m_ovl;

  task automatic model_edge(input bit r, input bit ld, input bit xv, input bit vv,
                            input logic [3:0] p, input bit ov);
    bit hit;
    for (int i = 0; i < 2; i++) begin
      if (r || ld) begin
        m_nbits[i] = 0;
        m_win[i]   = 0;
        m_rem[i]   = 0;
        m_pulse[i] = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        hit = 1'b0;
        if (vv) begin
          m_win[i] = ((m_win[i] << 1) | int'(xv)) % (1 << PAT_W);
          m_nbits[i]++;
          hit = (m_nbits[i] >= PAT_W) && (m_win[i] == m_pat);
        end
        if (hit) begin
          m_rem[i]   = m_hold[i];
          m_pulse[i] = 1'b1;
          if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
          if (!m_ovl) m_nbits[i] = 0;
        end else begin
          m_pulse[i] = 1'b0;
          if (m_rem[i] > 0) m_rem[i]--;
        end
      end
    end
    if (r) begin
      m_pat = 0;
      m_ovl = 1'b0;
    end else if (ld) begin
      m_pat = int'(p);
      m_ovl = ov;
    end
  endtask

  // Inputs change 1 time unit after a rising edge, so they are stable at
  // the next one; the model advances on the same edge the DUTs do.
  task automatic step(input bit xv, input bit vv, input bit ld = 1'b0,
                      input logic [3:0] p = 4'd0, input bit ov = 1'b0,
                      input bit r = 1'b0);
    rst          = r;
    if_a.x       = xv;  if_b.x       = xv;
    if_a.x_valid = vv;  if_b.x_valid = vv;
    if_a.load    = ld;  if_b.load    = ld;
    if_a.pattern = p;   if_b.pattern = p;
    if_a.overlap = ov;  if_b.overlap = ov;
    @(posedge clk);
    model_edge(r, ld, xv, vv, p, ov);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] b, input int n);
    logic [15:0] v;
    v = b;
    for (int k = n - 1; k >= 0; k--) step(v[k], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [3:0] p, input bit ov);
    step(1'b0, 1'b0, 1'b1, p, ov);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_y",     if_a.y,           32'(m_rem[0] > 0));
      check("a_pulse", if_a.match_pulse, 32'(m_pulse[0]));
      check("b_y",     if_b.y,           32'(m_rem[1] > 0));
      check("b_pulse", if_b.match_pulse, 32'(m_pulse[1]));
`ifdef SEQDET_MATCH_CNT_EN
      check("a_count", cnt_a, 32'(m_cnt[0]));
      check("b_count", cnt_b, 32'(m_cnt[1]));
`endif
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("lit_reset_y",     if_a.y, 0);
    check("lit_reset_pulse", if_a.match_pulse, 0);

    // Basic match, pattern 1011 non-overlapping.
    load_cfg(4'b1011, 1'b0);
    send_bits(16'b1011, 4);
    check("lit_basic_pulse", if_a.match_pulse, 1);
    check("lit_basic_y",     if_a.y, 1);
    idle(1);
    check("lit_basic_pulse_off", if_a.match_pulse, 0);
    check("lit_basic_y_hold",    if_a.y, 1);
    idle(1);
    check("lit_basic_y_off", if_a.y, 0);
    check("lit_basic_b_y",   if_b.y, 1);
    idle(4);

    // Overlapping mode: matches on bits 4 and 7.
    load_cfg(4'b1011, 1'b1);
    send_bits(16'b1011011, 7);
    check("lit_ovl_pulse7", if_a.match_pulse, 1);
    check("lit_ovl_y7",     if_a.y, 1);
    idle(5);

    // Non-overlapping mode: only bit 4 matches.
    load_cfg(4'b1011, 1'b0);
    send_bits(16'b1011011, 7);
    check("lit_novl_pulse7", if_a.match_pulse, 0);
    check("lit_novl_y7",     if_a.y, 0);
    idle(5);

    // Retrigger on the HOLD_CYC = 4 instance: five 1s, y high 5 cycles.
    load_cfg(4'b1111, 1'b1);
    send_bits(16'b1111, 4);
    check("lit_retrig_pulse4", if_b.match_pulse, 1);
    send_bits(16'b1, 1);
    check("lit_retrig_pulse5", if_b.match_pulse, 1);
    idle(3);
    check("lit_retrig_y_last", if_b.y, 1);
    idle(1);
    check("lit_retrig_y_off", if_b.y, 0);
    idle(2);

    // Gaps in x_valid: junk on x is ignored while invalid.
    load_cfg(4'b1011, 1'b0);
    send_bits(16'b10, 2);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    check("lit_gap_no_pulse", if_a.match_pulse, 0);
    send_bits(16'b11, 2);
    check("lit_gap_pulse", if_a.match_pulse, 1);
    idle(5);

    // load during the window: y falls, four fresh bits needed.
    load_cfg(4'b1011, 1'b0);
    send_bits(16'b1011, 4);
    check("lit_ld_y_before", if_a.y, 1);
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    check("lit_ld_y_after",     if_a.y, 0);
    check("lit_ld_pulse_after", if_a.match_pulse, 0);
    send_bits(16'b101, 3);
    check("lit_ld_3bits", if_a.match_pulse, 0);
    send_bits(16'b1, 1);
    check("lit_ld_4bits", if_a.match_pulse, 1);
    idle(5);

    // Counter saturation: eight 1s overlapping give five matches.
    load_cfg(4'b1111, 1'b1);
    send_bits(16'b11111111, 8);
`ifdef SEQDET_MATCH_CNT_EN
    check("lit_cnt_sat", cnt_a, 3);
`endif
    check("lit_cnt_y", if_a.y, 1);

    // Reset mid-window clears outputs and the pattern (now all zeros).
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    check("lit_rst_y",     if_a.y, 0);
    check("lit_rst_pulse", if_a.match_pulse, 0);
    check("lit_rst_b_y",   if_b.y, 0);
`ifdef SEQDET_MATCH_CNT_EN
    check("lit_rst_cnt", cnt_a, 0);
`endif
    send_bits(16'b000, 3);
    check("lit_rst_3zeros", if_a.match_pulse, 0);
    send_bits(16'b0, 1);
    check("lit_rst_pat_zero", if_a.match_pulse, 1);
    idle(6);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_n.md
# seq_detector_n

Parametrised serial pattern detector. It is the programmable successor to the team's fixed four-state Moore detector. The block watches a qualified serial bit stream for a runtime-loadable pattern of `PAT_W` bits, supports overlapping and non-overlapping match modes, and raises a registered match window for `HOLD_CYC` cycles. It sits between a serial front end (deserializer or line sampler) and control logic that needs a framed "pattern seen" indication.

## Interface
- `PAT_W`, 4: pattern length in bits, legal 2..16.
- `HOLD_CYC`, 2: length of the `y` window in cycles, legal 1..15.
- `CNT_W`, 8: match counter width. Used only with `SEQDET_MATCH_CNT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `x` in 1: serial data bit.
- `x_valid` in 1: qualifies `x`; the bit is consumed only when high.
- `pattern` in `PAT_W`: target pattern. MSB is the earliest-received bit.
- `overlap` in 1: mode, 1 = overlapping, 0 = non-overlapping.
- `load` in 1: latch `pattern` and `overlap`, then restart the search.
- `y` out 1: match window, high for `HOLD_CYC` cycles per match.
- `match_pulse` out 1: one-cycle strobe per detected match.
- `match_count` out `CNT_W`: saturating match count. Present only with the macro.

## Operation
- Internal registers:
  - `pat_q` and `ovl_q` hold the latched configuration.
  - Window shift register `sh` (`PAT_W` bits).
  - `fill` counts valid bits in the window, range 0..`PAT_W`, saturating.
  - `hold_cnt` (4 bits).
  - State register.
- States:
  - `S_SEARCH`: `y` = 0.
  - `S_HOLD`: `y` = 1.
- Bit accept (any state, `x_valid` = 1, no `load`/`rst`): `sh <= {sh[PAT_W-2:0], x}`; `fill <= min(fill+1, PAT_W)`.
- Match condition, evaluated on the accepted bit: post-shift `fill` == `PAT_W` and post-shift window == `pat_q`.
- On match, from either state:
  - Next state is `S_HOLD`, `hold_cnt <= HOLD_CYC-1`, `match_pulse <= 1`.
  - If `ovl_q` = 0, `fill <= 0` (window contents are don't-care). If `ovl_q` = 1, `fill` stays `PAT_W`.
- In `S_HOLD` with no match:
  - If `hold_cnt` == 0, go to `S_SEARCH`. Otherwise decrement `hold_cnt`.
  - A match during `S_HOLD` retriggers the window: `hold_cnt` reloads and a new pulse is issued.
- `load` (priority over bit accept):
  - `pat_q <= pattern`, `ovl_q <= overlap`.
  - `sh`, `fill` and `hold_cnt` cleared; state goes to `S_SEARCH`.
  - `y` and `match_pulse` go to 0.
  - The bit presented in a `load` cycle is dropped.
- `rst` (priority over everything): same effect as `load`, plus `pat_q` = 0 and `ovl_q` = 0.
- Outputs are registered (Moore). No combinational path from inputs to outputs.

## Timing
- Reset values: `y` = 0, `match_pulse` = 0, `match_count` = 0, state `S_SEARCH`, `fill` = 0, `pat_q` = 0.
- Latency: for the matching bit accepted at edge k, `y` and `match_pulse` are high after edge k. `match_pulse` is high for 1 cycle.
- Window length: `y` stays high exactly `HOLD_CYC` cycles after the last match.
- Retrigger: a match at window cycle j extends `y` to j + `HOLD_CYC` total cycles, with no gap in `y`.
- `x_valid` low: no shift, no match. `hold_cnt` still counts down.
- `load` or `rst` during `S_HOLD`: `y` is 0 from the next cycle. A fresh `PAT_W` bits are needed before the next match.
- The first match after `load` or `rst` needs at least `PAT_W` accepted bits.

## Configuration
- `SEQDET_MATCH_CNT_EN` defined:
  - `match_count` port exists and increments on each match, saturating at 2^`CNT_W`-1.
  - Cleared by `rst` and `load`.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `seq_det_pkg` holds:
  - State enum `t_state {S_SEARCH, S_HOLD}`.
  - Constants `PAT_W_MAX` = 16 and `HOLD_CYC_MAX` = 15.
- Sub-module `seq_det_window` contains the `sh` and `fill` registers and the comparator. It outputs `hit` combinationally to the parent FSM.
- The FSM, hold counter and output registers live in `seq_detector_n`.

## Test plan
- Basic match: `PAT_W`=4, `HOLD_CYC`=2, pattern 1011, overlap=0, bits 1,0,1,1 → `match_pulse` 1 cycle after the 4th bit, `y` high 2 cycles, then `y` = 0.
- Mode comparison, stream 1,0,1,1,0,1,1:
  - overlap=1 → matches on the 4th and 7th bits.
  - overlap=0 → exactly one match, on the 4th bit.
- Retrigger: `HOLD_CYC`=4, pattern 1111, overlap=1, five consecutive 1s → pulses after bits 4 and 5, `y` high 5 contiguous cycles.
- Gaps: bits 1,0, then `x_valid` low for 3 cycles, then 1,1 → single match after the last bit. `y` is unaffected during the gap.
- `load` during `S_HOLD`: `y` falls the next cycle. After 3 matching bits there is no match; the 4th matching bit produces a match.
- Reset and counter: with the macro, `CNT_W`=2, 5 matches → `match_count` = 3. `rst` mid-window → all outputs 0 the next cycle and `pat_q` = 0.
